// File: rtl/kf_pic_pkg.sv
// Shared constants and helpers for the kf_pic interrupt controller.
package kf_pic_pkg;

  localparam logic [2:0] AddrIrr   = 3'd0;
  localparam logic [2:0] AddrIsr   = 3'd1;
  localparam logic [2:0] AddrImr   = 3'd2;
  localparam logic [2:0] AddrTrig  = 3'd3;
  localparam logic [2:0] AddrVbase = 3'd4;
  localparam logic [2:0] AddrCtrl  = 3'd5;
  localparam logic [2:0] AddrEoi   = 3'd6;
  localparam logic [2:0] AddrPrio  = 3'd7;

  localparam int unsigned CtrlAutoEoiBit = 0;
  localparam int unsigned CtrlRotateBit  = 1;
  localparam int unsigned EoiSpecificBit = 8;

  localparam logic [31:0] ImrRst  = 32'hFFFF_FFFF;
  localparam logic [31:0] TrigRst = 32'hFFFF_FFFF;

  // Rank 0 is the highest priority: channel prio+1 ranks 0, channel prio ranks n-1.
  function automatic logic [4:0] prio_rank(logic [4:0] ch, logic [4:0] prio, int unsigned n);
    int unsigned r;
    r = (32'(ch) + n - 32'(prio) - 1) % n;
    return 5'(r);
  endfunction

endpackage

// File: rtl/kf_pic_if.sv
// Register bus, request lines and CPU handshake of the kf_pic controller.
interface kf_pic_if #(
  parameter int unsigned NUM_IRQ = 16
);
  logic                chip_select_n;
  logic                write_enable_n;
  logic                read_enable_n;
  logic [2:0]          address;
  logic [31:0]         data_bus_in;
  logic [31:0]         data_bus_out;
  logic                data_bus_io;
  logic [NUM_IRQ-1:0]  interrupt_request;
  logic                interrupt_to_cpu;
  logic                interrupt_acknowledge_n;
  logic                vector_valid;
  logic [7:0]          vector;

  modport slave (
    input  chip_select_n, write_enable_n, read_enable_n, address, data_bus_in,
    input  interrupt_request, interrupt_acknowledge_n,
    output data_bus_out, data_bus_io, interrupt_to_cpu, vector_valid, vector
  );

  modport master (
    output chip_select_n, write_enable_n, read_enable_n, address, data_bus_in,
    output interrupt_request, interrupt_acknowledge_n,
    input  data_bus_out, data_bus_io, interrupt_to_cpu, vector_valid, vector
  );
endinterface

// File: rtl/kf_pic_priority.sv
// Rotating priority encoder: returns the highest-priority set request for a given pointer.
module kf_pic_priority
  import kf_pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] req_i,
  input  logic [4:0]         prio_i,
  output logic               valid_o,
  output logic [4:0]         idx_o
);

  logic [5:0] best_rank;
  logic [4:0] rank;

  always_comb begin
    valid_o   = 1'b0;
    idx_o     = '0;
    best_rank = 6'h3F;
    rank      = '0;
    for (int unsigned c = 0; c < NUM_IRQ; c++) begin
      rank = prio_rank(5'(c), prio_i, NUM_IRQ);
      if (req_i[c] && ({1'b0, rank} < best_rank)) begin
        best_rank = {1'b0, rank};
        valid_o   = 1'b1;
        idx_o     = 5'(c);
      end
    end
  end

endmodule

// File: rtl/kf_pic_nchan.sv
// N-channel programmable interrupt controller with rotating priority and nesting.
module kf_pic_nchan
  import kf_pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ      = 16,
  parameter logic [7:0]  VEC_BASE_RST = 8'h08
) (
  input logic     clock,
  input logic     reset_n,
  kf_pic_if.slave bus
);

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  irq_vec_t   sync1_q, sync1_d, sync2_q, sync2_d, sync_prev_q, sync_prev_d;
  irq_vec_t   irr_edge_q, irr_edge_d, isr_q, isr_d, imr_q, imr_d, trig_q, trig_d;
  logic [7:0] vbase_q, vbase_d, vec_q, vec_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [4:0] prio_q, prio_d;
  logic       int_q, int_d, ack_prev_q, ack_prev_d, vv_q, vv_d;

  irq_vec_t   irr, req, edge_set, ack_set, ack_clr, eoi_clr, win_onehot, isr_onehot;
  logic       win_valid, isr_valid, eligible, ack_edge, wr, rd;
  logic [4:0] win_idx, isr_top;

  // Edge channels latch in irr_edge_q; level channels follow the synchronised line.
  assign irr        = (trig_q & irr_edge_q) | (~trig_q & sync2_q);
  assign req        = irr & ~imr_q;
  assign edge_set   = sync2_q & ~sync_prev_q;
  assign win_onehot = irq_vec_t'(1) << win_idx;
  assign isr_onehot = irq_vec_t'(1) << isr_top;
  assign ack_edge   = ack_prev_q & ~bus.interrupt_acknowledge_n;
  assign wr         = ~bus.chip_select_n & ~bus.write_enable_n;
  assign rd         = ~bus.chip_select_n & ~bus.read_enable_n;

  kf_pic_priority #(.NUM_IRQ(NUM_IRQ)) u_arb (
    .req_i   (req),
    .prio_i  (prio_q),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  kf_pic_priority #(.NUM_IRQ(NUM_IRQ)) u_isr (
    .req_i   (isr_q),
    .prio_i  (prio_q),
    .valid_o (isr_valid),
    .idx_o   (isr_top)
  );

  // Only the top request needs testing against in-service: lower ones cannot beat it.
  assign eligible = win_valid &&
                    (!isr_valid ||
                     (prio_rank(win_idx, prio_q, NUM_IRQ) < prio_rank(isr_top, prio_q, NUM_IRQ)));

  always_comb begin
    sync1_d     = bus.interrupt_request;
    sync2_d     = sync1_q;
    sync_prev_d = sync2_q;
    imr_d       = imr_q;
    trig_d      = trig_q;
    vbase_d     = vbase_q;
    ctrl_d      = ctrl_q;
    prio_d      = prio_q;
    int_d       = eligible;
    ack_prev_d  = bus.interrupt_acknowledge_n;
    vv_d        = 1'b0;
    vec_d       = vec_q;
    ack_set     = '0;
    ack_clr     = '0;
    eoi_clr     = '0;

    if (ack_edge) begin
      vv_d = 1'b1;
      if (eligible) begin
        vec_d = vbase_q + 8'(win_idx);
        if (!ctrl_q[CtrlAutoEoiBit]) begin
          ack_set = win_onehot;
        end else if (ctrl_q[CtrlRotateBit]) begin
          prio_d = win_idx;
        end
        if (trig_q[win_idx]) ack_clr = win_onehot;
      end else begin
        vec_d = vbase_q + 8'(NUM_IRQ - 1);
      end
    end

    // Written after the ack path so an EOI rotate or PRIO write overrides the auto-EOI rotate.
    if (wr) begin
      case (bus.address)
        AddrImr:   imr_d   = bus.data_bus_in[NUM_IRQ-1:0];
        AddrTrig:  trig_d  = bus.data_bus_in[NUM_IRQ-1:0];
        AddrVbase: vbase_d = bus.data_bus_in[7:0];
        AddrCtrl:  ctrl_d  = bus.data_bus_in[1:0];
        AddrPrio:  prio_d  = 5'(32'(bus.data_bus_in[4:0]) % NUM_IRQ);
        AddrEoi: begin
          if (bus.data_bus_in[EoiSpecificBit]) begin
            if (32'(bus.data_bus_in[4:0]) < NUM_IRQ) begin
              eoi_clr = irq_vec_t'(1) << bus.data_bus_in[4:0];
              if (ctrl_q[CtrlRotateBit]) prio_d = bus.data_bus_in[4:0];
            end
          end else if (isr_valid) begin
            eoi_clr = isr_onehot;
            if (ctrl_q[CtrlRotateBit]) prio_d = isr_top;
          end
        end
        default: ;
      endcase
    end

    irr_edge_d = ((irr_edge_q & ~ack_clr) | edge_set) & trig_q;
    isr_d      = (isr_q & ~eoi_clr) | ack_set;
  end

  always_comb begin
    bus.data_bus_out = '0;
    bus.data_bus_io  = ~rd;
    if (rd) begin
      case (bus.address)
        AddrIrr:   bus.data_bus_out = 32'(irr);
        AddrIsr:   bus.data_bus_out = 32'(isr_q);
        AddrImr:   bus.data_bus_out = 32'(imr_q);
        AddrTrig:  bus.data_bus_out = 32'(trig_q);
        AddrVbase: bus.data_bus_out = 32'(vbase_q);
        AddrCtrl:  bus.data_bus_out = 32'(ctrl_q);
        AddrPrio:  bus.data_bus_out = 32'(prio_q);
        default:   bus.data_bus_out = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_prev_q <= '0;
      irr_edge_q  <= '0;
      isr_q       <= '0;
      imr_q       <= ImrRst[NUM_IRQ-1:0];
      trig_q      <= TrigRst[NUM_IRQ-1:0];
      vbase_q     <= VEC_BASE_RST;
      ctrl_q      <= '0;
      prio_q      <= 5'(NUM_IRQ - 1);
      int_q       <= 1'b0;
      ack_prev_q  <= 1'b1;
      vv_q        <= 1'b0;
      vec_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_prev_q <= sync_prev_d;
      irr_edge_q  <= irr_edge_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      trig_q      <= trig_d;
      vbase_q     <= vbase_d;
      ctrl_q      <= ctrl_d;
      prio_q      <= prio_d;
      int_q       <= int_d;
      ack_prev_q  <= ack_prev_d;
      vv_q        <= vv_d;
      vec_q       <= vec_d;
    end
  end

  assign bus.interrupt_to_cpu = int_q;
  assign bus.vector_valid     = vv_q;
  assign bus.vector           = vec_q;

endmodule

// File: tb/tb_kf_pic_nchan.sv
// Self-checking bench for kf_pic_nchan: vector scoreboard plus register/output checks.
module tb_kf_pic_nchan;

  localparam int unsigned N = 16;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;
  int   n_vv;
  logic [7:0] exp_q[$];

  kf_pic_if #(.NUM_IRQ(N)) bus ();

  kf_pic_nchan #(.NUM_IRQ(N), .VEC_BASE_RST(8'h08)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard sink: every vector strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset_n && bus.vector_valid) begin
      n_vv++;
      if (exp_q.size() == 0) begin
        check("vv_unexpected", 32'(bus.vector_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("vector", 32'(bus.vector), 32'(e));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.chip_select_n  = 1'b0;
    bus.write_enable_n = 1'b0;
    bus.address        = addr;
    bus.data_bus_in    = data;
    @(posedge clk); #1;
    bus.chip_select_n  = 1'b1;
    bus.write_enable_n = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    @(posedge clk); #1;
    bus.chip_select_n = 1'b0;
    bus.read_enable_n = 1'b0;
    bus.address       = addr;
    #2;
    check(tag, bus.data_bus_out, exp);
    bus.chip_select_n = 1'b1;
    bus.read_enable_n = 1'b1;
  endtask

  task automatic pulse_irq(input int ch);
    @(posedge clk); #1;
    bus.interrupt_request[ch] = 1'b1;
    wait_cyc(3);
    bus.interrupt_request[ch] = 1'b0;
    wait_cyc(3);
  endtask

  task automatic do_ack(input logic [7:0] exp, input int hold);
    @(posedge clk); #1;
    bus.interrupt_acknowledge_n = 1'b0;
    exp_q.push_back(exp);
    repeat (hold) @(posedge clk);
    #1;
    bus.interrupt_acknowledge_n = 1'b1;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      check("vv_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vv_before;
    n_checks = 0;
    n_pass   = 0;
    n_vv     = 0;
    bus.chip_select_n           = 1'b1;
    bus.write_enable_n          = 1'b1;
    bus.read_enable_n           = 1'b1;
    bus.address                 = '0;
    bus.data_bus_in             = '0;
    bus.interrupt_request       = '0;
    bus.interrupt_acknowledge_n = 1'b1;
    reset_n = 1'b0;
    #3;
    check("rst_int", 32'(bus.interrupt_to_cpu), 32'd0);
    check("rst_vv", 32'(bus.vector_valid), 32'd0);
    check("rst_vec", 32'(bus.vector), 32'd0);
    check("idle_io", 32'(bus.data_bus_io), 32'd1);
    check("idle_dout", bus.data_bus_out, 32'd0);
    wait_cyc(2);
    reset_n = 1'b1;
    rd_chk("rst_imr", 3'd2, 32'h0000_FFFF);
    rd_chk("rst_vbase", 3'd4, 32'h08);
    rd_chk("rst_prio", 3'd7, 32'd15);
    rd_chk("eoi_read", 3'd6, 32'd0);

    // Scenario 1: single edge request
    wr_reg(3'd2, 32'h0);
    wr_reg(3'd4, 32'h20);
    pulse_irq(5);
    check("s1_int", 32'(bus.interrupt_to_cpu), 32'd1);
    rd_chk("s1_irr_pend", 3'd0, 32'h20);
    do_ack(8'h25, 1);
    rd_chk("s1_isr", 3'd1, 32'h20);
    rd_chk("s1_irr", 3'd0, 32'h0);
    wr_reg(3'd6, 32'h105);
    rd_chk("s1_isr_clr", 3'd1, 32'h0);

    // Scenario 2: rotation on non-specific EOI
    wr_reg(3'd5, 32'h2);
    pulse_irq(3);
    pulse_irq(9);
    do_ack(8'h23, 1);
    rd_chk("s2_isr", 3'd1, 32'h08);
    rd_chk("s2_irr", 3'd0, 32'h200);
    check("s2_int_blocked", 32'(bus.interrupt_to_cpu), 32'd0);
    wr_reg(3'd6, 32'h0);
    rd_chk("s2_prio", 3'd7, 32'd3);
    wait_cyc(2);
    check("s2_int", 32'(bus.interrupt_to_cpu), 32'd1);
    do_ack(8'h29, 1);
    wr_reg(3'd6, 32'h0);
    rd_chk("s2_prio2", 3'd7, 32'd9);
    wr_reg(3'd5, 32'h0);
    wr_reg(3'd7, 32'd20);
    rd_chk("prio_mod", 3'd7, 32'd4);
    wr_reg(3'd7, 32'd15);

    // Scenario 3: nesting
    pulse_irq(2);
    do_ack(8'h22, 1);
    pulse_irq(7);
    check("s3_int_masked", 32'(bus.interrupt_to_cpu), 32'd0);
    pulse_irq(1);
    check("s3_int_nest", 32'(bus.interrupt_to_cpu), 32'd1);
    do_ack(8'h21, 1);
    rd_chk("s3_isr", 3'd1, 32'h06);
    wr_reg(3'd6, 32'h114);
    rd_chk("s3_eoi_bad_id", 3'd1, 32'h06);
    wr_reg(3'd6, 32'h101);
    wr_reg(3'd6, 32'h102);
    wait_cyc(2);
    check("s3_int_7", 32'(bus.interrupt_to_cpu), 32'd1);
    do_ack(8'h27, 1);
    wr_reg(3'd6, 32'h0);
    rd_chk("s3_isr_end", 3'd1, 32'h0);

    // Scenario 4: spurious, and held acknowledge
    vv_before = n_vv;
    do_ack(8'h2F, 5);
    wait_cyc(3);
    check("s4_one_pulse", 32'(n_vv - vv_before), 32'd1);
    rd_chk("s4_isr", 3'd1, 32'h0);

    // Scenario 5: level mode and auto EOI
    wr_reg(3'd3, 32'hFFFE);
    @(posedge clk); #1;
    bus.interrupt_request[0] = 1'b1;
    wait_cyc(4);
    rd_chk("s5_irr_lvl", 3'd0, 32'h1);
    check("s5_int_lvl", 32'(bus.interrupt_to_cpu), 32'd1);
    bus.interrupt_request[0] = 1'b0;
    wait_cyc(4);
    rd_chk("s5_irr_drop", 3'd0, 32'h0);
    do_ack(8'h2F, 1);
    wr_reg(3'd5, 32'h1);
    pulse_irq(4);
    do_ack(8'h24, 1);
    rd_chk("s5_isr_auto", 3'd1, 32'h0);
    rd_chk("s5_irr_auto", 3'd0, 32'h0);

    // Scenario 6: reset during a pending acknowledge
    pulse_irq(6);
    check("s6_int", 32'(bus.interrupt_to_cpu), 32'd1);
    vv_before = n_vv;
    @(posedge clk); #1;
    bus.interrupt_acknowledge_n = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("s6_int_rst", 32'(bus.interrupt_to_cpu), 32'd0);
    check("s6_vv_rst", 32'(bus.vector_valid), 32'd0);
    check("s6_vec_rst", 32'(bus.vector), 32'd0);
    check("s6_io_rst", 32'(bus.data_bus_io), 32'd1);
    wait_cyc(2);
    bus.interrupt_acknowledge_n = 1'b1;
    check("s6_vv_hold", 32'(bus.vector_valid), 32'd0);
    wait_cyc(1);
    reset_n = 1'b1;
    wait_cyc(2);
    check("s6_no_pulse", 32'(n_vv - vv_before), 32'd0);
    rd_chk("s6_imr", 3'd2, 32'h0000_FFFF);
    rd_chk("s6_trig", 3'd3, 32'h0000_FFFF);
    rd_chk("s6_vbase", 3'd4, 32'h08);
    rd_chk("s6_ctrl", 3'd5, 32'h0);
    rd_chk("s6_prio", 3'd7, 32'd15);
    rd_chk("s6_isr", 3'd1, 32'h0);
    check("end_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
